// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder built around one 4-bit carry-lookahead slice, one chunk per cycle, LSB first.
// Optional build macro SEQ_ADD_SUB_EN adds a `sub` port that turns the operation into a - b.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for an operand request
  // S_RUN  | slice processes chunk idx_q each cycle
  // S_DONE | result held until the consumer takes it
  localparam int NCHUNK = WIDTH / 4;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [3:0]       sa, sb, sp, sg, ss;
  logic [4:0]       sc;

`ifdef SEQ_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  // Carries are fully expanded sum-of-products so the slice has no ripple path.
  always_comb begin
    sa = a_q[4*idx_q +: 4];
    sb = b_q[4*idx_q +: 4];
    sp = sa ^ sb;
    sg = sa & sb;
    sc[0] = carry_q;
    sc[1] = sg[0] | (sp[0] & sc[0]);
    sc[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & sc[0]);
    sc[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
          | (sp[2] & sp[1] & sp[0] & sc[0]);
    sc[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
          | (sp[3] & sp[2] & sp[1] & sg[0])
          | (sp[3] & sp[2] & sp[1] & sp[0] & sc[0]);
    ss = sp ^ sc[3:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = ss;
        carry_d = sc[4];
        if (idx_q == LAST_IDX) begin
          cout_d      = sc[4];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
